flappy_game_ctrl: RTL and testbench

//  Game sequencer for the 16x16 LED flappy-bird display. Owns the IDLE/PLAY/GAME_OVER state machine,

---
 rtl/flappy_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - flappy-bird game sequencer: state machine, bird physics, pipe scroll, score, blink.
// Optional: define FLAPPY_SCORE_SAT_EN to saturate Score at 8'hFF instead of wrapping.
module flappy_game_ctrl #(
  parameter logic [3:0] BIRD_X    = 4'd12,
  parameter int         GAP_SIZE  = 4,
  parameter int         GRAV_DIV  = 2,
  parameter int         PIPE_DIV  = 3,
  parameter int         BLINK_DIV = 4,
  parameter logic [3:0] FLAP_UP   = 4'd2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       flap,
  output logic [3:0] BirdY,
  output logic [3:0] PipeX,
  output logic [3:0] GapY,
  output logic [1:0] GameState,
  output logic       BlinkOn,
  output logic [7:0] Score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_BAD  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic       flap_q;
  logic       flap_pend;
  logic [7:0] grav_cnt;
  logic [7:0] pipe_cnt;
  logic [7:0] blink_cnt;

  logic       flap_edge;
  logic       flap_now;
  logic [3:0] pick;
  logic [3:0] bird_n;
  logic [3:0] pipe_n;
  logic [3:0] gap_n;
  logic [7:0] grav_n;
  logic [7:0] pcnt_n;
  logic [7:0] score_inc;
  logic       ground;
  logic       passed;
  logic       hit;

  assign GameState = state;
  assign flap_edge = flap & ~flap_q;
  assign flap_now  = flap_pend | flap_edge;
  assign pick      = (lfsr[3:0] > 4'd12) ? (lfsr[3:0] - 4'd8) : lfsr[3:0];

`ifdef FLAPPY_SCORE_SAT_EN
  assign score_inc = (Score == 8'hFF) ? 8'hFF : Score + 8'd1;
`else
  assign score_inc = Score + 8'd1;
`endif

  // Post-tick candidate values for PLAY; collision is judged on these.
  always_comb begin
    bird_n = BirdY;
    grav_n = grav_cnt;
    ground = 1'b0;
    if (flap_now) begin
      bird_n = (BirdY < FLAP_UP) ? 4'd0 : BirdY - FLAP_UP;
      grav_n = 8'd0;
    end else if (grav_cnt == 8'(GRAV_DIV - 1)) begin
      grav_n = 8'd0;
      ground = (BirdY >= 4'd14);
      bird_n = (BirdY == 4'd15) ? 4'd15 : BirdY + 4'd1;
    end else begin
      grav_n = grav_cnt + 8'd1;
    end

    pipe_n = PipeX;
    pcnt_n = pipe_cnt + 8'd1;
    gap_n  = GapY;
    passed = 1'b0;
    if (pipe_cnt == 8'(PIPE_DIV - 1)) begin
      pcnt_n = 8'd0;
      pipe_n = PipeX + 4'd1;
      if (PipeX == 4'd15) gap_n = pick;
      if (PipeX == BIRD_X) passed = 1'b1;
    end

    hit = ground ||
          ((pipe_n == BIRD_X) &&
           (({1'b0, bird_n} < {1'b0, gap_n}) ||
            ({1'b0, bird_n} >= ({1'b0, gap_n} + 5'(GAP_SIZE)))));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      BirdY     <= 4'd8;
      PipeX     <= 4'd0;
      GapY      <= 4'd6;
      BlinkOn   <= 1'b0;
      Score     <= 8'd0;
      lfsr      <= LFSR_SEED;
      flap_q    <= 1'b0;
      flap_pend <= 1'b0;
      grav_cnt  <= 8'd0;
      pipe_cnt  <= 8'd0;
      blink_cnt <= 8'd0;
    end else begin
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      flap_q <= flap;
      case (state)
        S_IDLE: begin
          if (flap_edge) begin
            state     <= S_PLAY;
            BirdY     <= 4'd8;
            PipeX     <= 4'd0;
            GapY      <= pick;
            Score     <= 8'd0;
            flap_pend <= 1'b0;
            grav_cnt  <= 8'd0;
            pipe_cnt  <= 8'd0;
            blink_cnt <= 8'd0;
          end
        end
        S_PLAY: begin
          if (tick) begin
            flap_pend <= 1'b0;
            PipeX     <= pipe_n;
            GapY      <= gap_n;
            grav_cnt  <= grav_n;
            pipe_cnt  <= pcnt_n;
            if (hit) begin
              state     <= S_OVER;
              BirdY     <= 4'd15;
              BlinkOn   <= 1'b1;
              blink_cnt <= 8'd0;
            end else begin
              BirdY <= bird_n;
              if (passed) Score <= score_inc;
            end
          end else if (flap_edge) begin
            flap_pend <= 1'b1;
          end
        end
        S_OVER: begin
          if (flap_edge) begin
            state     <= S_IDLE;
            BirdY     <= 4'd8;
            PipeX     <= 4'd0;
            GapY      <= 4'd6;
            BlinkOn   <= 1'b0;
            grav_cnt  <= 8'd0;
            pipe_cnt  <= 8'd0;
            blink_cnt <= 8'd0;
          end else if (tick) begin
            if (blink_cnt == 8'(BLINK_DIV - 1)) begin
              blink_cnt <= 8'd0;
              BlinkOn   <= ~BlinkOn;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        default: begin
          // Unused encoding: fall back to a clean IDLE.
          state     <= S_IDLE;
          BirdY     <= 4'd8;
          PipeX     <= 4'd0;
          GapY      <= 4'd6;
          BlinkOn   <= 1'b0;
          flap_pend <= 1'b0;
          grav_cnt  <= 8'd0;
          pipe_cnt  <= 8'd0;
          blink_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - directed self-checking bench for flappy_game_ctrl.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       flap;
  logic [3:0] BirdY;
  logic [3:0] PipeX;
  logic [3:0] GapY;
  logic [1:0] GameState;
  logic       BlinkOn;
  logic [7:0] Score;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] lfsr_m;
  logic [3:0] g;
  logic [3:0] exp_gap;
  int         cleared;
  int         exp_score;
  int         t;

  flappy_game_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .flap      (flap),
    .BirdY     (BirdY),
    .PipeX     (PipeX),
    .GapY      (GapY),
    .GameState (GameState),
    .BlinkOn   (BlinkOn),
    .Score     (Score)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded with A5, steps every clock.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_m <= 8'hA5;
    else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic [3:0] pick(input logic [7:0] l);
    logic [3:0] v;
    v = l[3:0];
    return (v > 4'd12) ? v - 4'd8 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_tick(input logic f);
    flap = f;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    flap = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_game(input int want, output logic [3:0] gap);
    flap = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      if (want < 0 || int'(pick(lfsr_m)) == want) break;
      @(negedge clk);
    end
    gap  = pick(lfsr_m);
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    @(negedge clk);
  endtask

  task automatic flap_once();
    flap = 1'b1;
    @(negedge clk);
    flap = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    tick    = 1'b0;
    flap    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(GameState), 32'd0);
    check("rst_bird",  32'(BirdY), 32'd8);
    check("rst_pipe",  32'(PipeX), 32'd0);
    check("rst_gap",   32'(GapY), 32'd6);
    check("rst_blink", 32'(BlinkOn), 32'd0);
    check("rst_score", 32'(Score), 32'd0);

    // Start straight out of reset: LFSR=A5 gives gap 5; held button = one flap.
    reset_n = 1'b1;
    flap    = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_state", 32'(GameState), 32'd1);
    check("hold_bird",  32'(BirdY), 32'd8);
    check("hold_pipe",  32'(PipeX), 32'd0);
    check("seed_gap",   32'(GapY), 32'd5);
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
    check("hold_noflap_bird", 32'(BirdY), 32'd9);
    flap = 1'b0;

    // Free fall to the ground, then blink.
    pulse_reset();
    start_game(-1, g);
    check("fall_gap", 32'(GapY), 32'(g));
    for (int i = 1; i <= 13; i++) begin
      do_tick(1'b0);
      if (i == 2)  check("fall_t2",  32'(BirdY), 32'd9);
      if (i == 13) check("fall_t13", 32'(BirdY), 32'd14);
    end
    check("fall_still_play", 32'(GameState), 32'd1);
    do_tick(1'b0);
    check("ground_state", 32'(GameState), 32'd3);
    check("ground_bird",  32'(BirdY), 32'd15);
    check("ground_blink", 32'(BlinkOn), 32'd1);
    check("ground_pipe",  32'(PipeX), 32'd4);
    for (int i = 1; i <= 8; i++) begin
      do_tick(1'b0);
      if (i == 3) check("blink_t3", 32'(BlinkOn), 32'd1);
      if (i == 4) check("blink_t4", 32'(BlinkOn), 32'd0);
      if (i == 8) check("blink_t8", 32'(BlinkOn), 32'd1);
    end
    check("over_frozen_bird", 32'(BirdY), 32'd15);
    flap_once();
    check("over_idle_state", 32'(GameState), 32'd0);
    check("over_idle_bird",  32'(BirdY), 32'd8);
    check("over_idle_pipe",  32'(PipeX), 32'd0);
    check("over_idle_gap",   32'(GapY), 32'd6);
    check("over_idle_blink", 32'(BlinkOn), 32'd0);

    // Gap 6, bird kept in 6..8 by flapping every 5th tick: clears the pipe.
    start_game(6, g);
    check("passA_gap", 32'(GapY), 32'd6);
    for (t = 1; t <= 39; t++) begin
      do_tick(t % 5 == 1);
      if (t == 36) begin
        check("passA_t36_state", 32'(GameState), 32'd1);
        check("passA_t36_bird",  32'(BirdY), 32'd6);
        check("passA_t36_pipe",  32'(PipeX), 32'd12);
      end
      if (t == 38) check("passA_t38_score", 32'(Score), 32'd0);
    end
    check("passA_score", 32'(Score), 32'd1);
    check("passA_state", 32'(GameState), 32'd1);
    check("passA_pipe",  32'(PipeX), 32'd13);
    for (int i = 0; i < 40 && GameState != 2'd3; i++) do_tick(1'b0);
    check("passA_over",        32'(GameState), 32'd3);
    check("passA_over_score",  32'(Score), 32'd1);
    flap_once();
    check("passA_idle_score",  32'(Score), 32'd1);

    // Gap 6, bird held at 2..4: hits the pipe with BirdY=3.
    start_game(6, g);
    check("hitB_score0", 32'(Score), 32'd0);
    for (t = 1; t <= 36; t++) begin
      do_tick(t <= 3 || t % 5 == 3);
      if (t == 35) begin
        check("hitB_t35_state", 32'(GameState), 32'd1);
        check("hitB_t35_bird",  32'(BirdY), 32'd3);
      end
    end
    check("hitB_state", 32'(GameState), 32'd3);
    check("hitB_score", 32'(Score), 32'd0);
    check("hitB_bird",  32'(BirdY), 32'd15);
    check("hitB_pipe",  32'(PipeX), 32'd12);
    flap_once();

    // Flap saturation at row 0 and flap beating gravity on the same tick.
    start_game(-1, g);
    begin
      logic       fl[8];
      logic [3:0] ey[8];
      fl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      ey = '{4'd6, 4'd4, 4'd2, 4'd2, 4'd3, 4'd1, 4'd1, 4'd0};
      for (int i = 0; i < 8; i++) begin
        do_tick(fl[i]);
        check($sformatf("flapC_t%0d", i + 1), 32'(BirdY), 32'(ey[i]));
      end
    end

    // Autopilot through 257 pipes: score wrap/saturate and gap range.
    pulse_reset();
    start_game(-1, g);
    check("pilot_gap0", 32'(GapY), 32'(g));
    cleared = 0;
    for (t = 1; t < 13000 && cleared < 257; t++) begin
      exp_gap = pick(lfsr_m);
      do_tick(32'(BirdY) > 32'(GapY) + 1);
      if (t % 48 == 0) begin
        check("pilot_gap",   32'(GapY), 32'(exp_gap));
        check("gap_range",   32'(GapY <= 4'd12), 32'd1);
      end
      if (t % 48 == 39) begin
        cleared++;
`ifdef FLAPPY_SCORE_SAT_EN
        exp_score = (cleared > 255) ? 255 : cleared;
`else
        exp_score = cleared % 256;
`endif
        check("pilot_score", 32'(Score), 32'(exp_score));
      end
    end
    check("pilot_done",  32'(cleared), 32'd257);
    check("pilot_state", 32'(GameState), 32'd1);

    // Asynchronous reset in the middle of a game.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(GameState), 32'd0);
    check("mid_rst_bird",  32'(BirdY), 32'd8);
    check("mid_rst_pipe",  32'(PipeX), 32'd0);
    check("mid_rst_gap",   32'(GapY), 32'd6);
    check("mid_rst_blink", 32'(BlinkOn), 32'd0);
    check("mid_rst_score", 32'(Score), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) do_tick(1'b0);
    check("mid_rst_idle_state", 32'(GameState), 32'd0);
    check("mid_rst_idle_bird",  32'(BirdY), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
